// File: rtl/id_stage_param.sv
// Instruction-decode stage: register file, ID forwarding, branch
// compare, hazard detection, next-PC select and the ID/EX register.
module id_stage_param #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [31:0]       inst,
    input  logic              is_branch,
    input  logic              is_jump,
    input  logic              is_jr,
    input  logic              uses_rt,
    input  logic              sign_ext,
    input  logic [2:0]        cmp_mode,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [AW-1:0]     ex_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [AW-1:0]     mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              flush_if,
    output logic [1:0]        pc_sel,
    output logic [DATA_W-1:0] pc_target,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_rd_o
);

    localparam logic [AW-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] imm_ext, fwd_a, fwd_b;
    logic [DATA_W-1:0] br_target, j_target;
    logic              taken, uses_a_cmp;
    logic              match_ex, match_mem;
    logic              unused_bits;

    assign rs = inst[21+AW-1:21];
    assign rt = inst[16+AW-1:16];
    assign rd = inst[11+AW-1:11];
    assign unused_bits = ^inst[31:26];

    assign imm_ext = sign_ext ? {{(DATA_W-16){inst[15]}}, inst[15:0]}
                              : {{(DATA_W-16){1'b0}}, inst[15:0]};
    assign br_target = pc + {imm_ext[DATA_W-3:0], 2'b00};
    assign j_target  = {pc[DATA_W-1:28], inst[25:0], 2'b00};

    // MEM ALU result beats WB data beats the file; a WB hit also
    // gives the same-cycle write-through on the read ports.
    function automatic logic [DATA_W-1:0] pick(
        input logic [AW-1:0]     a,
        input logic [DATA_W-1:0] rf,
        input logic              m_fw,
        input logic [AW-1:0]     m_rd,
        input logic [DATA_W-1:0] m_res,
        input logic              w_fw,
        input logic [AW-1:0]     w_rd,
        input logic [DATA_W-1:0] w_dat
    );
        if (R0_ZERO && a == ZERO_A) return '0;
        if (m_fw && m_rd == a)      return m_res;
        if (w_fw && w_rd == a)      return w_dat;
        return rf;
    endfunction

    // Register file: cleared on reset, single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_reg_write && !(R0_ZERO && wb_rd == ZERO_A)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Forwarded operands feeding the comparator and ID/EX
    always_comb begin
        fwd_a = pick(rs, regs[rs], mem_reg_write && !mem_mem_read,
                     mem_rd, mem_result, wb_reg_write, wb_rd, wb_data);
        fwd_b = pick(rt, regs[rt], mem_reg_write && !mem_mem_read,
                     mem_rd, mem_result, wb_reg_write, wb_rd, wb_data);
    end

    // Branch condition; zero compares are signed on operand A
    always_comb begin
        taken = 1'b0;
        case (cmp_mode)
            3'd0:    taken = (fwd_a == fwd_b);
            3'd1:    taken = (fwd_a != fwd_b);
            3'd2:    taken = fwd_a[DATA_W-1] || (fwd_a == '0);
            3'd3:    taken = !fwd_a[DATA_W-1] && (fwd_a != '0);
            3'd4:    taken = fwd_a[DATA_W-1];
            3'd5:    taken = !fwd_a[DATA_W-1];
            default: taken = 1'b0;
        endcase
    end

    // Hazard detection: load-use and branch/jr operand dependencies
    always_comb begin
        uses_a_cmp = is_branch || is_jr;
        match_ex  = (ex_rd != ZERO_A) &&
                    ((ex_rd == rs) || (uses_rt && ex_rd == rt));
        match_mem = (mem_rd != ZERO_A) &&
                    ((mem_rd == rs) || (uses_rt && mem_rd == rt));
        stall = id_valid &&
                ((ex_mem_read && match_ex) ||
                 (uses_a_cmp && ex_reg_write && match_ex) ||
                 (uses_a_cmp && mem_mem_read && match_mem));
    end

    // Next-PC selection; jr outranks jump outranks branch
    always_comb begin
        pc_sel    = 2'd0;
        pc_target = pc;
        if (id_valid && !stall) begin
            if (is_jr) begin
                pc_sel    = 2'd3;
                pc_target = fwd_a;
            end else if (is_jump) begin
                pc_sel    = 2'd1;
                pc_target = j_target;
            end else if (is_branch && taken) begin
                pc_sel    = 2'd2;
                pc_target = br_target;
            end
        end
        flush_if = (pc_sel != 2'd0);
    end

    // ID/EX register; stalls and empty slots become bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd_o    <= '0;
        end else if (stall || !id_valid) begin
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd_o    <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_rs_data <= fwd_a;
            ex_rt_data <= fwd_b;
            ex_imm     <= imm_ext;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd_o    <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param: comb outputs checked in-cycle, ID/EX
// contents checked through an expected-value queue.
module tb_id_stage_param;

    typedef struct {
        logic        v;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_branch, is_jump, is_jr, uses_rt, sign_ext;
    logic [2:0]  cmp_mode;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, flush_if;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd_o;

    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;
    exp_t sb[$];

    id_stage_param dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .pc(pc),
        .inst(inst), .is_branch(is_branch), .is_jump(is_jump),
        .is_jr(is_jr), .uses_rt(uses_rt), .sign_ext(sign_ext),
        .cmp_mode(cmp_mode), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .flush_if(flush_if), .pc_sel(pc_sel),
        .pc_target(pc_target), .ex_valid(ex_valid),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd_o(ex_rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t bub();
        exp_t e;
        e.v = 1'b0; e.a = '0; e.b = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.rd = '0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] a, b, imm,
                                input logic [4:0] rs, rt, rd);
        exp_t e;
        e.v = 1'b1; e.a = a; e.b = b; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd;
        return e;
    endfunction

    task automatic chk_ex(input exp_t e);
        chk("ex_valid", ex_valid, e.v);
        chk("ex_rs_data", ex_rs_data, e.a);
        chk("ex_rt_data", ex_rt_data, e.b);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs", ex_rs, e.rs);
        chk("ex_rt", ex_rt, e.rt);
        chk("ex_rd_o", ex_rd_o, e.rd);
    endtask

    // Pop one expected ID/EX image per edge while the bench runs
    always @(posedge clk) begin
        if (run) begin
            #2;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk_ex(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic idle();
        id_valid = 0; pc = '0; inst = '0;
        is_branch = 0; is_jump = 0; is_jr = 0; uses_rt = 0;
        sign_ext = 0; cmp_mode = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_rd = '0;
        mem_reg_write = 0; mem_mem_read = 0; mem_rd = '0;
        mem_result = '0;
        wb_reg_write = 0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic id(input logic [4:0] rs, rt, input logic [15:0] imm);
        id_valid = 1;
        inst = {6'h00, rs, rt, imm};
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_reg_write = 1; wb_rd = rd; wb_data = d;
    endtask

    // Check comb outputs, queue the ID/EX image, advance one cycle
    task automatic step(input logic e_stall, input logic e_flush,
                        input logic [1:0] e_sel, input logic [31:0] e_tgt,
                        input exp_t e);
        #1;
        chk("stall", stall, e_stall);
        chk("flush_if", flush_if, e_flush);
        chk("pc_sel", pc_sel, e_sel);
        chk("pc_target", pc_target, e_tgt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #2;
        chk_ex(bub());
        @(posedge clk); #1;
        rst_n = 1;
        run = 1;

        idle(); wb(1, 32'd7);          step(0, 0, 0, 0, bub());
        idle(); wb(2, 32'd7);          step(0, 0, 0, 0, bub());
        idle(); wb(4, 32'hFFFF_FFFF);  step(0, 0, 0, 0, bub());
        idle(); wb(6, 32'h400);        step(0, 0, 0, 0, bub());
        idle(); wb(3, 32'h33);         step(0, 0, 0, 0, bub());

        // write-through on same-cycle read
        idle(); pc = 32'h100; id(5, 0, 16'h0); wb(5, 32'hAA);
        step(0, 0, 0, 32'h100, mk(32'hAA, 0, 0, 5, 0, 0));
        idle(); pc = 32'h100; id(0, 5, 16'h8); uses_rt = 1; sign_ext = 1;
        step(0, 0, 0, 32'h100, mk(0, 32'hAA, 8, 0, 5, 0));

        // load-use stall, then no forward from a load in MEM
        idle(); pc = 32'h100; id(1, 3, 16'h1800); uses_rt = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3;
        step(1, 0, 0, 32'h100, bub());
        idle(); pc = 32'h100; id(1, 3, 16'h1800); uses_rt = 1;
        mem_reg_write = 1; mem_mem_read = 1; mem_rd = 3;
        mem_result = 32'hDEAD;
        step(0, 0, 0, 32'h100, mk(7, 32'h33, 32'h1800, 1, 3, 3));

        // beq taken / bne not taken
        idle(); pc = 32'h100; id(1, 2, 16'h4); is_branch = 1;
        uses_rt = 1; sign_ext = 1; cmp_mode = 0;
        step(0, 1, 2, 32'h110, mk(7, 7, 4, 1, 2, 0));
        cmp_mode = 1;
        step(0, 0, 0, 32'h100, mk(7, 7, 4, 1, 2, 0));

        // bltz taken backwards, bgez not taken, zero-extended imm
        idle(); pc = 32'h200; id(4, 0, 16'hFFFC); is_branch = 1;
        sign_ext = 1; cmp_mode = 4;
        step(0, 1, 2, 32'h1F0, mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 4, 0, 31));
        sign_ext = 0; cmp_mode = 5;
        step(0, 0, 0, 32'h200, mk(32'hFFFF_FFFF, 0, 32'h0000_FFFC, 4, 0, 31));

        // bgtz on positive, never-taken mode 6
        idle(); pc = 32'h200; id(1, 0, 16'h4); is_branch = 1;
        sign_ext = 1; cmp_mode = 3;
        step(0, 1, 2, 32'h210, mk(7, 0, 4, 1, 0, 0));
        cmp_mode = 6;
        step(0, 0, 0, 32'h200, mk(7, 0, 4, 1, 0, 0));

        // jump
        idle(); pc = 32'h1000_0100; id_valid = 1;
        inst = {6'h02, 5'd0, 5'd9, 16'h3456}; is_jump = 1;
        step(0, 1, 1, 32'h1024_D158, mk(0, 0, 32'h3456, 0, 9, 6));

        // jr from file, from MEM forward, stalled on EX producer
        idle(); pc = 32'h100; id(6, 0, 16'h0); is_jr = 1;
        step(0, 1, 3, 32'h400, mk(32'h400, 0, 0, 6, 0, 0));
        mem_reg_write = 1; mem_rd = 6; mem_result = 32'h800;
        step(0, 1, 3, 32'h800, mk(32'h800, 0, 0, 6, 0, 0));
        idle(); pc = 32'h100; id(6, 0, 16'h0); is_jr = 1;
        ex_reg_write = 1; ex_rd = 6;
        step(1, 0, 0, 32'h100, bub());

        // MEM forward beats WB forward
        idle(); pc = 32'h100; id(10, 10, 16'h0); uses_rt = 1;
        mem_reg_write = 1; mem_rd = 10; mem_result = 32'h11;
        wb(10, 32'h22);
        step(0, 0, 0, 32'h100, mk(32'h11, 32'h11, 0, 10, 10, 0));

        // rt not used: load in EX on rt does not stall
        idle(); pc = 32'h100; id(1, 3, 16'h0);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3;
        step(0, 0, 0, 32'h100, mk(7, 32'h33, 0, 1, 3, 0));

        // r0: write dropped, no forwarding, no stall
        idle(); pc = 32'h100; id(0, 0, 16'h0); uses_rt = 1;
        wb(0, 32'hFFFF_FFFF);
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'h55;
        ex_mem_read = 1; ex_rd = 0;
        step(0, 0, 0, 32'h100, mk(0, 0, 0, 0, 0, 0));
        idle(); pc = 32'h100; id(0, 0, 16'h0);
        step(0, 0, 0, 32'h100, mk(0, 0, 0, 0, 0, 0));

        // beq on a load in EX: two stall cycles, then WB value
        idle(); pc = 32'h100; id(1, 2, 16'h4); is_branch = 1;
        uses_rt = 1; sign_ext = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2;
        step(1, 0, 0, 32'h100, bub());
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        mem_reg_write = 1; mem_mem_read = 1; mem_rd = 2;
        mem_result = 32'hBAD;
        step(1, 0, 0, 32'h100, bub());
        mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0;
        wb(2, 32'd8);
        step(0, 0, 0, 32'h100, mk(7, 8, 4, 1, 2, 0));

        // reset mid-operation during a stall
        idle(); pc = 32'h100; id(1, 0, 16'h0);
        step(0, 0, 0, 32'h100, mk(7, 0, 0, 1, 0, 0));
        ex_mem_read = 1; ex_rd = 1;
        #2;
        run = 0;
        chk("sb_drained", sb.size(), 0);
        rst_n = 0;
        #1;
        chk_ex(bub());
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        chk("ex_valid_post_rst", ex_valid, 0);
        idle(); pc = 32'h100; id(1, 2, 16'h0); uses_rt = 1;
        run = 1;
        step(0, 0, 0, 32'h100, mk(0, 0, 0, 1, 2, 0));
        idle();
        step(0, 0, 0, 0, bub());
        #3;
        run = 0;
        chk("sb_end_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
